// File: rtl/tlb_repl_if.sv
// ---------------------------------------------------------------------------
// tlb_repl_if
//   Signal bundle between a TLB lookup/refill agent and tlb_repl_ctrl.
//
//   hit_valid    agent -> ctrl  lookup hit this cycle
//   hit_bit[8]   agent -> ctrl  one-hot hit way vector (qualified by hit_valid)
//   miss_valid   agent -> ctrl  refill victim requested
//   miss_ready   ctrl -> agent  controller idle, will accept a miss
//   victim_valid ctrl -> agent  victim_way valid and stable
//   victim_way   ctrl -> agent  way chosen for refill
//   refill_done  agent -> ctrl  refill written into victim_way
//   refill_abort agent -> ctrl  refill cancelled (page-walk fault)
//   flush        agent -> ctrl  invalidate all ways
//   plru_state   ctrl -> agent  tree-PLRU bits (bit0 unused, always 0)
//   valid_vec    ctrl -> agent  per-way valid bits
//
//   slave  : the controller side
//   master : the agent side
// ---------------------------------------------------------------------------
interface tlb_repl_if;
  logic       hit_valid;
  logic [7:0] hit_bit;
  logic       miss_valid;
  logic       miss_ready;
  logic       victim_valid;
  logic [2:0] victim_way;
  logic       refill_done;
  logic       refill_abort;
  logic       flush;
  logic [7:0] plru_state;
  logic [7:0] valid_vec;

  modport slave (
    input  hit_valid, hit_bit, miss_valid, refill_done, refill_abort, flush,
    output miss_ready, victim_valid, victim_way, plru_state, valid_vec
  );

  modport master (
    output hit_valid, hit_bit, miss_valid, refill_done, refill_abort, flush,
    input  miss_ready, victim_valid, victim_way, plru_state, valid_vec
  );
endinterface

// File: rtl/tlb_repl_ctrl.sv
// ---------------------------------------------------------------------------
// tlb_repl_ctrl
//   Replacement controller for an 8-way TLB. Keeps a 7-node tree pseudo-LRU
//   (nodes 1..7, node 1 is the root, 2..3 second level, 4..7 leaves) plus a
//   valid bit per way, and hands out a refill victim through a two-state
//   miss/refill handshake.
//
//   Ports:
//     clk    sole clock, rising edge
//     reset  synchronous active-high reset, overrides every input
//     bus    tlb_repl_if.slave (see rtl/tlb_repl_if.sv for the signal list)
//
//   Configuration:
//     TLB_REPL_INVALID_FIRST_EN  when defined, a miss accepted while any way
//                                is invalid picks the lowest-index invalid way;
//                                otherwise (and in the default build) the
//                                victim is always the tree-PLRU choice.
// ---------------------------------------------------------------------------
module tlb_repl_ctrl (
  input  logic        clk,
  input  logic        reset,
  tlb_repl_if.slave   bus
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t     state_reg,  state_next;
  logic [7:0] plru_reg,   plru_next;
  logic [7:0] valid_reg,  valid_next;
  logic [2:0] victim_reg, victim_next;

  logic [2:0] hit_way;
  logic       hit_upd;
  logic [2:0] accept_victim;
  logic [7:0] victim_onehot;
  logic [7:0] plru_after_hit;

  genvar gi;

  // OR-reduction encoder. Exact for one-hot vectors; for multi-hot vectors
  // it still gives a fixed, well-defined (non-priority) index.
  function automatic logic [2:0] encode_or(input logic [7:0] vec);
    logic [3:0] nib;
    logic [1:0] pair;
    nib  = vec[7:4] | vec[3:0];
    pair = nib[3:2] | nib[1:0];
    return {|vec[7:4], |nib[3:2], pair[1]};
  endfunction

  // Mark way {a,b,c} most recently used: each node on its path is pointed
  // at the opposite subtree.
  function automatic logic [7:0] plru_touch(input logic [7:0] p,
                                            input logic [2:0] way);
    logic [7:0] r;
    r                              = p;
    r[1]                           = ~way[2];
    r[{2'b01, way[2]}]             = ~way[1];
    r[{1'b1, way[2], way[1]}]      = ~way[0];
    r[0]                           = 1'b0;
    return r;
  endfunction

  // Follow the node bits from the root down to a leaf.
  function automatic logic [2:0] plru_victim(input logic [7:0] p);
    logic a;
    logic b;
    logic c;
    a = p[1];
    b = p[{2'b01, a}];
    c = p[{1'b1, a, b}];
    return {a, b, c};
  endfunction

  assign hit_way = encode_or(bus.hit_bit);
  assign hit_upd = bus.hit_valid & (|bus.hit_bit);

  // One-hot form of the held victim, used to set its valid bit on refill.
  generate
    for (gi = 0; gi < 8; gi++) begin : g_victim_dec
      assign victim_onehot[gi] = (victim_reg == 3'(gi));
    end
  endgenerate

`ifdef TLB_REPL_INVALID_FIRST_EN
  logic [7:0] invalid_vec;
  logic [7:0] below_invalid;
  logic [7:0] first_invalid;

  assign invalid_vec      = ~valid_reg;
  assign below_invalid[0] = 1'b0;

  // below_invalid[i]: some way with a lower index is already invalid.
  generate
    for (gi = 1; gi < 8; gi++) begin : g_below_inv
      assign below_invalid[gi] = |invalid_vec[gi-1:0];
    end
  endgenerate

  assign first_invalid = invalid_vec & ~below_invalid;
  assign accept_victim = (valid_reg != 8'hFF) ? encode_or(first_invalid)
                                              : plru_victim(plru_reg);
`else
  assign accept_victim = plru_victim(plru_reg);
`endif

  // A hit is folded in first; a refill committing in the same cycle then
  // updates on top of the post-hit tree.
  assign plru_after_hit = hit_upd ? plru_touch(plru_reg, hit_way) : plru_reg;

  always_comb begin
    state_next  = state_reg;
    victim_next = victim_reg;
    plru_next   = plru_after_hit;
    valid_next  = valid_reg;

    case (state_reg)
      IDLE: begin
        if (bus.miss_valid) begin
          victim_next = accept_victim;
          state_next  = WAIT;
        end
      end
      WAIT: begin
        // victim_reg is deliberately never touched here so the way handed
        // to the refill agent stays stable for the whole refill.
        if (bus.refill_done) begin
          plru_next  = plru_touch(plru_after_hit, victim_reg);
          valid_next = valid_reg | victim_onehot;
          state_next = IDLE;
        end else if (bus.refill_abort) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Flush only invalidates; it wins over a simultaneous refill's valid set
    // but leaves the tree and the handshake alone.
    if (bus.flush) begin
      valid_next = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      plru_reg   <= 8'h00;
      valid_reg  <= 8'h00;
      victim_reg <= 3'd0;
    end else begin
      state_reg  <= state_next;
      plru_reg   <= plru_next;
      valid_reg  <= valid_next;
      victim_reg <= victim_next;
    end
  end

  assign bus.miss_ready   = (state_reg == IDLE);
  assign bus.victim_valid = (state_reg == WAIT);
  assign bus.victim_way   = victim_reg;
  assign bus.plru_state   = plru_reg;
  assign bus.valid_vec    = valid_reg;

endmodule
